queue: RTL and testbench

Multi-lane FIFO queue, the in-order counterpart to the team's multi-lane LIFO stack, with the same port protocol. Up to PUSH entries are written and up to POP entries are read per cycle. The oldest entries are always presented on the read lanes. Sits between producer and consumer pipeline stages that need arrival-order buffering, for example fetch-to-decode and retire queues.

---
 rtl/queue_pkg.sv | 17 +
 rtl/queue_lane_count.sv | 24 ++
 rtl/queue.sv | 100 ++++++++++
 tb/tb_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared width helpers for the multi-lane queue (and its stack sibling).
package queue_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bits needed to hold a lane count 0..lanes.
    function automatic int lane_cw(input int lanes);
        return (lanes > 0) ? $clog2(lanes + 1) : 1;
    endfunction

endpackage

// File: rtl/queue_lane_count.sv
// Counts contiguous asserted (active-low) lanes starting at lane 0; a gap ends the run.
module lane_count
    import queue_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]          i_lanes_,
    output logic [lane_cw(WIDTH)-1:0] o_cnt
);

    localparam int CW = lane_cw(WIDTH);

    logic w_run;

    always_comb begin
        w_run = 1'b1;
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_run = w_run & ~i_lanes_[i];
            if (w_run) o_cnt = CW'(i + 1);
        end
    end

endmodule

// File: rtl/queue.sv
// Multi-lane in-order FIFO: up to PUSH writes and POP reads per cycle, oldest on lane 0.
// Optional same-cycle empty bypass from wd lane 0 to rd lane 0 under `QUEUE_BYPASS_EN.
module queue
    import queue_pkg::*;
#(
    parameter int DATA  = 32,
    parameter int DEPTH = 16,
    parameter int PUSH  = 1,
    parameter int POP   = 1
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 flush_,
    input  logic [PUSH-1:0]      push_,
    input  logic [PUSH*DATA-1:0] wd,
    input  logic [POP-1:0]       pop_,
    output logic [POP*DATA-1:0]  rd,
    output logic [POP-1:0]       v,
    output logic                 busy
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = lane_cw(PUSH);
    localparam int QW = lane_cw(POP);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW:0] PUSH_C  = (CW+1)'(PUSH);

    logic [DATA-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_head, r_tail;
    logic [CW-1:0]   r_cnt;

    logic [PW-1:0]   w_np_raw;
    logic [QW-1:0]   w_nq_raw;
    logic [CW-1:0]   w_np, w_nq, w_wofs;
    logic            w_byp, w_take;

    lane_count #(.WIDTH(PUSH)) u_push_cnt (.i_lanes_(push_),     .o_cnt(w_np_raw));
    // Pops on lanes without a valid entry are masked off before counting.
    lane_count #(.WIDTH(POP))  u_pop_cnt  (.i_lanes_(pop_ | ~v), .o_cnt(w_nq_raw));

    // Same-cycle pops are deliberately not credited toward free space.
    assign busy = (DEPTH_C - {1'b0, r_cnt}) < PUSH_C;

`ifdef QUEUE_BYPASS_EN
    assign w_byp  = reset_ && flush_ && !busy && (r_cnt == '0) && !push_[0];
    assign w_take = w_byp && !pop_[0];
`else
    assign w_byp  = 1'b0;
    assign w_take = 1'b0;
`endif

    always_comb begin
        w_np   = busy   ? '0 : CW'(w_np_raw);
        w_nq   = w_take ? '0 : CW'(w_nq_raw);
        // A bypassed-and-consumed lane 0 never lands in storage.
        w_wofs = w_take ? CW'(1) : '0;
    end

    always_comb begin
        rd = '0;
        v  = '0;
        for (int i = 0; i < POP; i++) begin
            if (CW'(i) < r_cnt) begin
                v[i]                 = 1'b1;
                rd[i*DATA +: DATA]   = r_mem[r_head + AW'(i)];
            end
        end
        if (w_byp) begin
            v[0]          = 1'b1;
            rd[DATA-1:0]  = wd[DATA-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (!flush_) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_head <= r_head + AW'(w_nq);
            r_tail <= r_tail + AW'(w_np - w_wofs);
            r_cnt  <= r_cnt + w_np - w_wofs - w_nq;
        end
    end

    always_ff @(posedge clk) begin
        if (flush_) begin
            for (int i = 0; i < PUSH; i++) begin
                if ((CW'(i) < w_np) && (CW'(i) >= w_wofs))
                    r_mem[r_tail + AW'(i) - AW'(w_wofs)] <= wd[i*DATA +: DATA];
            end
        end
    end

endmodule

// File: tb/tb_queue.sv
// Scoreboard bench for queue (DATA=32, DEPTH=16, PUSH=2, POP=2); honours QUEUE_BYPASS_EN.
module tb_queue;

    localparam int DATA  = 32;
    localparam int DEPTH = 16;
    localparam int PUSH  = 2;
    localparam int POP   = 2;

    logic                 clk    = 1'b0;
    logic                 reset_ = 1'b0;
    logic                 flush_ = 1'b1;
    logic [PUSH-1:0]      push_  = '1;
    logic [PUSH*DATA-1:0] wd     = '0;
    logic [POP-1:0]       pop_   = '1;
    logic [POP*DATA-1:0]  rd;
    logic [POP-1:0]       v;
    logic                 busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];

    queue #(.DATA(DATA), .DEPTH(DEPTH), .PUSH(PUSH), .POP(POP)) dut (
        .clk(clk), .reset_(reset_), .flush_(flush_), .push_(push_), .wd(wd),
        .pop_(pop_), .rd(rd), .v(v), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ncont(input logic [1:0] l_);
        if (l_[0]) return 0;
        if (l_[1]) return 1;
        return 2;
    endfunction

    // Drive one cycle, check outputs against the scoreboard, then retire the cycle in the model.
    task automatic step(input logic [1:0] pu, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] po, input logic fl);
        int          sz, np, nq, st;
        logic        eb, byp, take;
        logic [31:0] e0, e1;
        push_ = pu;
        wd    = {d1, d0};
        pop_  = po;
        flush_ = fl;
        #1;
        sz  = sb.size();
        eb  = (DEPTH - sz) < PUSH;
        byp = 1'b0;
`ifdef QUEUE_BYPASS_EN
        byp = (sz == 0) && !pu[0] && fl && !eb;
`endif
        e0 = (sz > 0) ? sb[0] : (byp ? d0 : 32'h0);
        e1 = (sz > 1) ? sb[1] : 32'h0;
        chk("busy", 64'(busy), 64'(eb));
        chk("v", 64'(v), 64'({sz > 1, (sz > 0) || byp}));
        chk("rd0", 64'(rd[31:0]), 64'(e0));
        chk("rd1", 64'(rd[63:32]), 64'(e1));
        @(posedge clk);
        if (!fl) begin
            sb.delete();
        end else begin
            take = byp && !po[0];
            np   = eb ? 0 : ncont(pu);
            nq   = take ? 0 : ((ncont(po) < sz) ? ncont(po) : sz);
            repeat (nq) sb.delete(0);
            st = take ? 1 : 0;
            for (int i = st; i < np; i++) sb.push_back((i == 0) ? d0 : d1);
        end
        #1;
    endtask

    task automatic idle();
        step(2'b11, 32'h0, 32'h0, 2'b11, 1'b1);
    endtask

    initial begin
        push_ = 2'b00;
        wd    = {32'hcafef00d, 32'h0badf00d};
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_v", 64'(v), 64'(0));
            chk("rst_rd", 64'(rd), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end
        reset_ = 1'b1;
        sb.delete();

        step(2'b10, 32'hdeadbeef, 32'h0, 2'b11, 1'b1);
        idle();
        step(2'b11, 32'h0, 32'h0, 2'b10, 1'b1);
        step(2'b01, 32'h0000aaaa, 32'h0000bbbb, 2'b11, 1'b1);
        idle();

        step(2'b00, 32'hdeadbeef, 32'hdeadbef0, 2'b11, 1'b1);
        step(2'b10, 32'hdeadbef1, 32'h0, 2'b11, 1'b1);
        step(2'b11, 32'h0, 32'h0, 2'b00, 1'b1);
        idle();
        step(2'b11, 32'h0, 32'h0, 2'b01, 1'b1);
        step(2'b11, 32'h0, 32'h0, 2'b10, 1'b1);
        idle();

        for (int k = 0; k < 8; k++) step(2'b00, 32'h100 + 32'(2*k), 32'h101 + 32'(2*k), 2'b11, 1'b1);
        step(2'b00, 32'hdead0001, 32'hdead0002, 2'b11, 1'b1);
        step(2'b11, 32'h0, 32'h0, 2'b00, 1'b1);
        idle();
        repeat (8) step(2'b11, 32'h0, 32'h0, 2'b00, 1'b1);

        step(2'b00, 32'h300, 32'h301, 2'b11, 1'b1);
        step(2'b10, 32'h302, 32'h0, 2'b11, 1'b1);
        step(2'b00, 32'h303, 32'h304, 2'b00, 1'b1);
        idle();
        repeat (3) step(2'b11, 32'h0, 32'h0, 2'b10, 1'b1);

        for (int k = 0; k < 10; k++) begin
            step(2'b00, 32'h200 + 32'(2*k), 32'h201 + 32'(2*k), 2'b11, 1'b1);
            step(2'b11, 32'h0, 32'h0, 2'b00, 1'b1);
        end

        step(2'b00, 32'h400, 32'h401, 2'b11, 1'b1);
        step(2'b00, 32'h402, 32'h403, 2'b00, 1'b0);
        idle();

`ifdef QUEUE_BYPASS_EN
        step(2'b10, 32'h12345678, 32'h0, 2'b11, 1'b1);
        step(2'b11, 32'h0, 32'h0, 2'b10, 1'b1);
        step(2'b10, 32'h12345678, 32'h0, 2'b10, 1'b1);
        idle();
        step(2'b00, 32'h12345679, 32'h1234567a, 2'b10, 1'b1);
        idle();
        step(2'b11, 32'h0, 32'h0, 2'b00, 1'b1);
`endif

        repeat (300) step(2'($urandom), $urandom, $urandom, 2'($urandom),
                          ($urandom_range(0, 24) != 0));

        repeat (3) step(2'b00, $urandom, $urandom, 2'b11, 1'b1);
        push_  = 2'b11;
        pop_   = 2'b11;
        reset_ = 1'b0;
        #1;
        chk("mid_rst_v", 64'(v), 64'(0));
        chk("mid_rst_rd", 64'(rd), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        sb.delete();
        idle();
        step(2'b10, 32'h55aa55aa, 32'h0, 2'b11, 1'b1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
